retire_monitor: RTL and testbench

RETIRE_MONITOR -- requirements
Module: retire_monitor

---
 rtl/retire_monitor.sv | 183 ++++++++++++++++++
 tb/tb_retire_monitor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/retire_monitor.sv
// retire_monitor
//   Watches the instruction retirement stream of a core and keeps run
//   statistics (cycles, instructions, control transfers, mispredictions).
//   Detects a core spinning on one PC (halt) and a core that stopped
//   retiring (watchdog timeout); both are terminal until i_clear or reset.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for the first retirement, nothing counts
//   RUN     | counting; watchdog and halt detector armed
//   HALTED  | HALT_REPEAT consecutive retirements of one PC; frozen
//   TIMEOUT | WDT_CYCLES cycles without a retirement; frozen
//
// Ports
//   i_clk, i_reset (async, active-low), i_clear (sync clear)
//   i_insn_vld, i_ctrl, i_mispred, i_pc_debug : retirement stream
//   o_cycle_cnt, o_insn_cnt, o_ctrl_cnt, o_mispred_cnt : saturating counters
//   o_state, o_done, o_timeout, o_halt_pc : status
module retire_monitor #(
    parameter int CNT_W       = 32,
    parameter int PC_W        = 32,
    parameter int WDT_CYCLES  = 1000,
    parameter int HALT_REPEAT = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_insn_vld,
    input  logic             i_ctrl,
    input  logic             i_mispred,
    input  logic [PC_W-1:0]  i_pc_debug,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_insn_cnt,
    output logic [CNT_W-1:0] o_ctrl_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt,
    output logic [1:0]       o_state,
    output logic             o_done,
    output logic             o_timeout,
    output logic [PC_W-1:0]  o_halt_pc
);

    generate
        if (HALT_REPEAT < 2) begin : g_bad_halt_repeat
            $error("retire_monitor: HALT_REPEAT must be at least 2");
        end
        if (WDT_CYCLES < 1) begin : g_bad_wdt_cycles
            $error("retire_monitor: WDT_CYCLES must be at least 1");
        end
    endgenerate

    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    localparam int REP_W = $clog2(HALT_REPEAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t           state_q, state_nx;
    logic [CNT_W-1:0] cycle_q, cycle_nx;
    logic [CNT_W-1:0] insn_q, insn_nx;
    logic [CNT_W-1:0] ctrl_q, ctrl_nx;
    logic [CNT_W-1:0] mis_q, mis_nx;
    logic [WDT_W-1:0] wdt_q, wdt_nx;
    logic [REP_W-1:0] rep_q, rep_nx;
    logic [PC_W-1:0]  prev_pc_q, prev_pc_nx;
    logic [PC_W-1:0]  halt_pc_q, halt_pc_nx;
    logic             done_q, done_nx;
    logic             timeout_q, timeout_nx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        state_nx   = state_q;
        cycle_nx   = cycle_q;
        insn_nx    = insn_q;
        ctrl_nx    = ctrl_q;
        mis_nx     = mis_q;
        wdt_nx     = wdt_q;
        rep_nx     = rep_q;
        prev_pc_nx = prev_pc_q;
        halt_pc_nx = halt_pc_q;

        if (i_clear) begin
            state_nx   = ST_IDLE;
            cycle_nx   = '0;
            insn_nx    = '0;
            ctrl_nx    = '0;
            mis_nx     = '0;
            wdt_nx     = '0;
            rep_nx     = '0;
            prev_pc_nx = '0;
            halt_pc_nx = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_insn_vld) begin
                        // The waking retirement is the first one of the run:
                        // it has no predecessor, so the repeat count starts at 1.
                        state_nx   = ST_RUN;
                        cycle_nx   = sat_inc(cycle_q, 1'b1);
                        insn_nx    = sat_inc(insn_q, 1'b1);
                        ctrl_nx    = sat_inc(ctrl_q, i_ctrl);
                        mis_nx     = sat_inc(mis_q, i_mispred);
                        wdt_nx     = '0;
                        rep_nx     = REP_W'(1);
                        prev_pc_nx = i_pc_debug;
                    end
                end
                ST_RUN: begin
                    cycle_nx = sat_inc(cycle_q, 1'b1);
                    insn_nx  = sat_inc(insn_q, i_insn_vld);
                    ctrl_nx  = sat_inc(ctrl_q, i_insn_vld & i_ctrl);
                    mis_nx   = sat_inc(mis_q, i_insn_vld & i_mispred);
                    if (i_insn_vld) begin
                        wdt_nx     = '0;
                        rep_nx     = (i_pc_debug == prev_pc_q) ? rep_q + REP_W'(1)
                                                               : REP_W'(1);
                        prev_pc_nx = i_pc_debug;
                    end else begin
                        wdt_nx = wdt_q + WDT_W'(1);
                    end
                    // Halt is checked first so it wins over a coincident expiry.
                    if (i_insn_vld && (rep_nx == REP_W'(HALT_REPEAT))) begin
                        state_nx   = ST_HALTED;
                        halt_pc_nx = i_pc_debug;
                    end else if (wdt_nx == WDT_W'(WDT_CYCLES)) begin
                        state_nx = ST_TIMEOUT;
                    end
                end
                default: begin
                    // HALTED / TIMEOUT hold everything.
                end
            endcase
        end

        done_nx    = (state_nx == ST_HALTED) || (state_nx == ST_TIMEOUT);
        timeout_nx = (state_nx == ST_TIMEOUT);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            cycle_q   <= '0;
            insn_q    <= '0;
            ctrl_q    <= '0;
            mis_q     <= '0;
            wdt_q     <= '0;
            rep_q     <= '0;
            prev_pc_q <= '0;
            halt_pc_q <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_nx;
            cycle_q   <= cycle_nx;
            insn_q    <= insn_nx;
            ctrl_q    <= ctrl_nx;
            mis_q     <= mis_nx;
            wdt_q     <= wdt_nx;
            rep_q     <= rep_nx;
            prev_pc_q <= prev_pc_nx;
            halt_pc_q <= halt_pc_nx;
            done_q    <= done_nx;
            timeout_q <= timeout_nx;
        end
    end

    assign o_cycle_cnt   = cycle_q;
    assign o_insn_cnt    = insn_q;
    assign o_ctrl_cnt    = ctrl_q;
    assign o_mispred_cnt = mis_q;
    assign o_state       = state_q;
    assign o_done        = done_q;
    assign o_timeout     = timeout_q;
    assign o_halt_pc     = halt_pc_q;

endmodule

// File: tb/tb_retire_monitor.sv
// Testbench for retire_monitor: one default-parameter instance plus a
// CNT_W=4 instance sharing the same stimulus for the saturation case.
// Expected snapshots are queued by the stimulus and compared by a monitor.
module tb_retire_monitor;

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2, S_TMO = 2'd3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        clear = 1'b0;
    logic        insn_vld = 1'b0;
    logic        ctrl = 1'b0;
    logic        mispred = 1'b0;
    logic [31:0] pc = '0;

    logic [31:0] a_cyc, a_insn, a_ctl, a_mis, a_hpc;
    logic [1:0]  a_state;
    logic        a_done, a_tmo;

    logic [3:0]  b_cyc, b_insn, b_ctl, b_mis;
    logic [31:0] b_hpc;
    logic [1:0]  b_state;
    logic        b_done, b_tmo;

    always #5 clk = ~clk;

    retire_monitor dut_a (
        .i_clk(clk), .i_reset(reset_n), .i_clear(clear), .i_insn_vld(insn_vld),
        .i_ctrl(ctrl), .i_mispred(mispred), .i_pc_debug(pc),
        .o_cycle_cnt(a_cyc), .o_insn_cnt(a_insn), .o_ctrl_cnt(a_ctl),
        .o_mispred_cnt(a_mis), .o_state(a_state), .o_done(a_done),
        .o_timeout(a_tmo), .o_halt_pc(a_hpc)
    );

    retire_monitor #(.CNT_W(4)) dut_b (
        .i_clk(clk), .i_reset(reset_n), .i_clear(clear), .i_insn_vld(insn_vld),
        .i_ctrl(ctrl), .i_mispred(mispred), .i_pc_debug(pc),
        .o_cycle_cnt(b_cyc), .o_insn_cnt(b_insn), .o_ctrl_cnt(b_ctl),
        .o_mispred_cnt(b_mis), .o_state(b_state), .o_done(b_done),
        .o_timeout(b_tmo), .o_halt_pc(b_hpc)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [1:0]  state;
        logic [31:0] cyc, insn, ctl, mis;
        logic        done, tmo;
        logic [31:0] hpc;
    } exp_t;

    exp_t sb_q[$];
    event chk_ev;
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic check_field(input string name, input string field,
                               input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h at %0t", name, field, act, exp, $time);
        end
    endtask

    // Monitor: drains the scoreboard whenever the stimulus signals that the
    // DUT outputs are settled for the queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.sel == 0) begin
                    check_field(e.name, "state",   {30'd0, a_state}, {30'd0, e.state});
                    check_field(e.name, "cycle",   a_cyc,  e.cyc);
                    check_field(e.name, "insn",    a_insn, e.insn);
                    check_field(e.name, "ctrl",    a_ctl,  e.ctl);
                    check_field(e.name, "mispred", a_mis,  e.mis);
                    check_field(e.name, "done",    {31'd0, a_done}, {31'd0, e.done});
                    check_field(e.name, "timeout", {31'd0, a_tmo},  {31'd0, e.tmo});
                    check_field(e.name, "halt_pc", a_hpc,  e.hpc);
                end else begin
                    check_field(e.name, "w4.state",   {30'd0, b_state}, {30'd0, e.state});
                    check_field(e.name, "w4.cycle",   {28'd0, b_cyc},  e.cyc);
                    check_field(e.name, "w4.insn",    {28'd0, b_insn}, e.insn);
                    check_field(e.name, "w4.ctrl",    {28'd0, b_ctl},  e.ctl);
                    check_field(e.name, "w4.mispred", {28'd0, b_mis},  e.mis);
                    check_field(e.name, "w4.done",    {31'd0, b_done}, {31'd0, e.done});
                    check_field(e.name, "w4.timeout", {31'd0, b_tmo},  {31'd0, e.tmo});
                    check_field(e.name, "w4.halt_pc", b_hpc, e.hpc);
                end
            end
        end
    end

    task automatic expect_st(input string name, input int sel, input logic [1:0] st,
                             input logic [31:0] cyc, input logic [31:0] insn,
                             input logic [31:0] ctl, input logic [31:0] mis,
                             input logic done, input logic tmo, input logic [31:0] hpc);
        exp_t e;
        e.name = name; e.sel = sel; e.state = st;
        e.cyc = cyc; e.insn = insn; e.ctl = ctl; e.mis = mis;
        e.done = done; e.tmo = tmo; e.hpc = hpc;
        sb_q.push_back(e);
        -> chk_ev;
    endtask

    task automatic expect_zero(input string name, input int sel);
        expect_st(name, sel, S_IDLE, 0, 0, 0, 0, 1'b0, 1'b0, 0);
    endtask

    // One clock: drive at the falling edge, return 1 time unit after the rise.
    task automatic step(input logic v, input logic c, input logic m,
                        input logic [31:0] p, input logic clr);
        @(negedge clk);
        insn_vld = v; ctrl = c; mispred = m; pc = p; clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic ret(input logic [31:0] p);
        step(1'b1, 1'b0, 1'b0, p, 1'b0);
    endtask

    // Non-retiring cycles with ctrl/mispred high, which must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, got time %0t", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        // Reset, with a retirement presented across the first edge.
        #1 reset_n = 1'b0;
        insn_vld = 1'b1;
        #2;
        expect_zero("reset", 0);
        expect_zero("reset", 1);
        @(posedge clk); #1;
        expect_zero("reset_edge", 0);
        @(negedge clk);
        reset_n = 1'b1; insn_vld = 1'b0;

        idle(5000);
        expect_zero("idle_5000", 0);

        // PCs 0,4,8(branch,mispred), then 0xC four times
        ret(32'h0);
        expect_st("halt_first", 0, S_RUN, 1, 1, 0, 0, 1'b0, 1'b0, 0);
        ret(32'h4);
        step(1'b1, 1'b1, 1'b1, 32'h8, 1'b0);
        expect_st("halt_mid", 0, S_RUN, 3, 3, 1, 1, 1'b0, 1'b0, 0);
        ret(32'hC); ret(32'hC); ret(32'hC);
        expect_st("halt_pre", 0, S_RUN, 6, 6, 1, 1, 1'b0, 1'b0, 0);
        ret(32'hC);
        expect_st("halt_hit", 0, S_HALT, 7, 7, 1, 1, 1'b1, 1'b0, 32'hC);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 32'h40, 1'b0);
        idle(2);
        expect_st("halt_frozen", 0, S_HALT, 7, 7, 1, 1, 1'b1, 1'b0, 32'hC);

        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        expect_zero("clear_halted", 0);

        // Repeat count holds across a bubble and restarts on a new PC
        ret(32'h20); ret(32'h20);
        idle(1);
        ret(32'h20); ret(32'h24); ret(32'h24); ret(32'h24);
        expect_st("rep_pre", 0, S_RUN, 7, 6, 0, 0, 1'b0, 1'b0, 0);
        ret(32'h24);
        expect_st("rep_hit", 0, S_HALT, 8, 7, 0, 0, 1'b1, 1'b0, 32'h24);

        // Clear together with a retirement mid-RUN
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        expect_zero("clear2", 0);
        ret(32'h100);
        step(1'b1, 1'b1, 1'b0, 32'h104, 1'b0);
        expect_st("pre_clear", 0, S_RUN, 2, 2, 1, 0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b1, 32'h108, 1'b1);
        expect_zero("clear_with_ret", 0);
        ret(32'h10C);
        expect_st("after_clear", 0, S_RUN, 1, 1, 0, 0, 1'b0, 1'b0, 0);

        // Watchdog: kicked by a retirement, expires on the 1000th quiet cycle
        idle(999);
        expect_st("wdt_999", 0, S_RUN, 1000, 1, 0, 0, 1'b0, 1'b0, 0);
        ret(32'h110);
        expect_st("wdt_kick", 0, S_RUN, 1001, 2, 0, 0, 1'b0, 1'b0, 0);
        idle(999);
        expect_st("wdt_999b", 0, S_RUN, 2000, 2, 0, 0, 1'b0, 1'b0, 0);
        idle(1);
        expect_st("wdt_hit", 0, S_TMO, 2001, 2, 0, 0, 1'b1, 1'b1, 0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1, 32'h114, 1'b0);
        idle(3);
        expect_st("wdt_frozen", 0, S_TMO, 2001, 2, 0, 0, 1'b1, 1'b1, 0);

        // Saturation on the CNT_W=4 instance: 20 distinct-PC branches,
        // mispredicted on even indices.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        expect_zero("clear3", 0);
        expect_zero("clear3", 1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, (i % 2 == 0), 32'h1000 + 32'(4 * i), 1'b0);
            if (i == 14) expect_st("sat_15", 1, S_RUN, 15, 15, 15, 8, 1'b0, 1'b0, 0);
            if (i == 15) expect_st("sat_16", 1, S_RUN, 15, 15, 15, 8, 1'b0, 1'b0, 0);
        end
        expect_st("sat_20", 1, S_RUN, 15, 15, 15, 10, 1'b0, 1'b0, 0);
        expect_st("nosat_20", 0, S_RUN, 20, 20, 20, 10, 1'b0, 1'b0, 0);

        // Asynchronous reset between edges mid-RUN
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        expect_zero("async_rst", 0);
        expect_zero("async_rst", 1);
        insn_vld = 1'b1; ctrl = 1'b1; pc = 32'h300;
        @(posedge clk); #1;
        expect_zero("rst_hold", 0);
        @(negedge clk);
        reset_n = 1'b1; insn_vld = 1'b0; ctrl = 1'b0;
        idle(3);
        expect_zero("post_rst_idle", 0);
        ret(32'h304);
        expect_st("post_rst_run", 0, S_RUN, 1, 1, 0, 0, 1'b0, 1'b0, 0);

        #1;
        if (sb_q.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
